// File: rtl/rv_imm_pkg.sv
// rtl/rv_imm_pkg.sv - shared formats, opcodes and helpers for the immediate generator
package rv_imm_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // CSR-immediate variants (csrrwi/csrrsi/csrrci) are the SYSTEM ops with funct3[2] set
    function automatic logic is_csr_imm(input logic [31:0] instr);
        return (instr[6:0] == OP_SYSTEM) && instr[14];
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode-to-format decode and immediate assembly (CSR uimm under IMM_CSR_EN)
module imm_decode
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        zext;

    // Pick the format from the opcode and gather the raw immediate bits into a 32-bit word
    always_comb begin
        fmt   = FMT_NONE;
        imm32 = 32'd0;
        zext  = 1'b0;
        unique case (instr[6:0])
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM_32: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
`ifdef IMM_CSR_EN
            OP_SYSTEM: begin
                if (is_csr_imm(instr)) begin
                    fmt   = FMT_Z;
                    imm32 = {27'd0, instr[19:15]};
                    zext  = 1'b1;
                end
            end
`endif
            default: begin
                fmt   = FMT_NONE;
                imm32 = 32'd0;
            end
        endcase
    end

    // Widen to XLEN: instr[31] is the sign for every format except the zero-extended CSR uimm
    always_comb begin
        if (zext) begin
            imm = XLEN'(imm32);
        end else begin
            imm = XLEN'($signed(imm32));
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with skid buffer and tag side-band (optional IMM_CSR_EN)
module imm_gen_pipe
    import rv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    imm_fmt_t        dec_fmt;
    logic [XLEN-1:0] dec_imm;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (in_instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    imm_fmt_t         out_fmt_q,   out_fmt_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    imm_fmt_t         skid_fmt_q,   skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic accept;
    logic out_free;

    // Ready depends only on the registered skid state; held low while reset is asserted
    assign in_ready  = rst_n & ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign out_free  = ~out_valid_q | out_ready;

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;
    assign out_tag   = out_tag_q;

    // Next-state for the output stage and the skid entry; flush drops everything
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry goes first; no accept is possible while it is full
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new entry in the skid register
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_tag_d   = in_tag;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    import rv_imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready,  in_ready64;
    logic        out_valid, out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt,   out_fmt64;
    logic [31:0] out_tag,   out_tag64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready), .out_imm (out_imm),
        .out_fmt (out_fmt), .out_tag (out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready64), .in_instr (in_instr), .in_tag (in_tag),
        .out_valid (out_valid64), .out_ready (out_ready), .out_imm (out_imm64),
        .out_fmt (out_fmt64), .out_tag (out_tag64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with out_ready=1 and check the result one cycle later
    task automatic vec(input string name, input logic [31:0] instr, input logic [31:0] tag,
                       input logic [31:0] e32, input logic [63:0] e64, input logic [2:0] efmt);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        tick();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_imm32"}, 64'(out_imm), 64'(e32));
        chk({name, "_imm64"}, out_imm64, e64);
        chk({name, "_fmt"}, 64'(out_fmt), 64'(efmt));
        chk({name, "_fmt64"}, 64'(out_fmt64), 64'(efmt));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    initial begin
        logic [31:0] csr_e32;
        logic [2:0]  csr_fmt;
`ifdef IMM_CSR_EN
        csr_e32 = 32'd5;
        csr_fmt = FMT_Z;
`else
        csr_e32 = 32'd0;
        csr_fmt = FMT_NONE;
`endif
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_tag = 32'd0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'(FMT_NONE));
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Back-to-back formats at full throughput
        vec("addi", 32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I);
        vec("sw",   32'hFE112E23, 32'h1004, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S);
        vec("beq",  32'hFE000CE3, 32'h1008, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_B);
        vec("jal",  32'hFFDFF06F, 32'h100C, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J);
        vec("lui",  32'h123452B7, 32'h1010, 32'h12345000, 64'h0000000012345000, FMT_U);
        vec("luin", 32'h800002B7, 32'h1014, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U);
        vec("csr",  32'h3002D0F3, 32'h1018, csr_e32, 64'(csr_e32), csr_fmt);
        vec("add",  32'h00000033, 32'h101C, 32'h0, 64'h0, FMT_NONE);
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: A held, B skidded, C waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'hA;
        tick();
        chk("bp_a_valid", 64'(out_valid), 64'd1);
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        in_instr = 32'h00200093; in_tag = 32'hB;
        tick();
        chk("bp_b_hold_tag", 64'(out_tag), 64'hA);
        chk("bp_b_in_ready", 64'(in_ready), 64'd0);
        in_instr = 32'h00300093; in_tag = 32'hC;
        tick();
        chk("bp_c_hold_tag", 64'(out_tag), 64'hA);
        chk("bp_c_hold_imm", 64'(out_imm), 64'd1);
        chk("bp_c_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b_tag", 64'(out_tag), 64'hB);
        chk("bp_out_b_imm", 64'(out_imm), 64'd2);
        chk("bp_out_b_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_c_tag", 64'(out_tag), 64'hC);
        chk("bp_out_c_imm", 64'(out_imm), 64'd3);
        chk("bp_out_c_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // Flush with output and skid full, D presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'h20;
        tick();
        in_tag = 32'h21;
        tick();
        chk("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_tag = 32'hD;
        tick();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_d_dropped", 64'(out_valid), 64'd0);

        // Flush wins over an accept while the skid is free
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 32'h30;
        tick();
        flush = 1'b1; in_tag = 32'hE;
        tick();
        chk("fl2_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl2_e_dropped", 64'(out_valid), 64'd0);

        // Reset mid-stream
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h40;
        tick();
        chk("mr_loaded", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_imm", 64'(out_imm), 64'd0);
        chk("mr_out_fmt", 64'(out_fmt), 64'(FMT_NONE));
        chk("mr_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("mr_in_ready_after", 64'(in_ready), 64'd1);
        chk("mr_out_valid_after", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Decode-stage immediate generator, parametrised successor to the single-cycle RV32 immediate unit. Derives the immediate format from the opcode itself and sign-extends to XLEN. Registers the result with a valid/ready handshake and a 2-entry skid buffer, carrying a side-band tag (PC). Sits between fetch/IF-ID register and the ALU operand muxes.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
TAG_W, 32, width of side-band tag carried alongside the instruction

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  drop all buffered entries (branch mispredict/trap)
in_valid  input  1  instruction word valid
in_ready  output  1  block can accept an instruction this cycle
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  side-band tag (PC)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  format code (package enum)
out_tag  output  TAG_W  tag of the instruction producing out_imm

Behaviour:
- One clock; reset is synchronous, active-low; clk/rst_n.
- Reset (rst_n=0 at edge): out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_tag=0, skid empty. in_ready=0 while rst_n=0; 1 the first cycle after release.
- Format decode on in_instr[6:0]:
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 1100111, 0000011, 0010011, 0011011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - all others -> NONE, imm=0
- Immediate layout:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - Sign bit is always instr[31], replicated up to XLEN (U included, so XLEN=64 sign-extends bit 31).
- Handshake:
  - Transfer on valid&ready at each side.
  - Latency 1 cycle: an accepted instruction appears on out_* the next cycle when the output stage is empty or draining.
  - Output stage: out_* held stable while out_valid=1 and out_ready=0.
  - Skid entry: an accept while the output stage is stalled writes the skid entry.
  - in_ready = ~skid_valid, a registered term; no combinational in->out ready path.
  - When the output drains and skid is full, skid moves to the output next cycle and in_ready rises.
  - Strict FIFO order; zero bubbles at full throughput when out_ready stays 1.
- flush:
  - At the edge it clears out_valid and skid_valid; data regs don't care.
  - Flush wins over a simultaneous in_valid&in_ready (input dropped) and over simultaneous out_ready (the presented entry counts as consumed/dropped).
- Reset mid-operation: all entries discarded; identical to the reset state.
- out_fmt/out_imm/out_tag change only at accept/advance edges.

Optional Feature:
- IMM_CSR_EN defined:
  - Opcode 1110011 with instr[14]=1 decodes as FMT_Z.
  - imm = zero-extended instr[19:15] (CSR uimm); no sign extension.
- IMM_CSR_EN undefined: opcode 1110011 -> FMT_NONE, imm=0.

Decomposition:
- Package rv_imm_pkg:
  - fmt enum FMT_NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6
  - opcode localparams
  - imm_fmt_t typedef
- Sub-module imm_decode (combinational): instr -> {fmt, imm[XLEN-1:0]}.
- imm_gen_pipe instantiates imm_decode and holds the output register plus skid register.

Test Plan:
- XLEN=32, out_ready=1:
  - 0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFFFFFF, fmt I
  - 0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt S
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt B
  - 0xFFDFF06F (jal -4) -> 0xFFFFFFFC, fmt J
- 0x123452B7 (lui 0x12345):
  - XLEN=32 -> 0x12345000, fmt U
  - XLEN=64 -> 0x0000000012345000
  - 0x800002B7 at XLEN=64 -> 0xFFFFFFFF80000000
- Backpressure:
  - out_ready=0, present A,B,C back-to-back -> A held on out_*, B in skid, in_ready=0 while C waits.
  - Raise out_ready -> A,B,C emerge in order on consecutive cycles, no duplicates.
- Flush:
  - Output and skid full, assert flush with in_valid=1 (instr D) -> next cycle out_valid=0, in_ready=1, D never appears.
- Reset:
  - rst_n=0 for 1 cycle mid-stream -> out_valid=0, out_imm=0, out_fmt=FMT_NONE, in_ready=0 during reset, 1 after.
- 0x3002D0F3 (csrrwi x1, 0x300, 5):
  - with IMM_CSR_EN -> imm=5, fmt Z
  - without -> imm=0, fmt NONE
  - 0x00000033 (add) -> imm=0, fmt NONE in both builds.
